// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types, widths and age compare for the ALU arbiter
//
// Purpose: arbiter FSM state type, the ALU request/answer layouts, their flattened
//          widths, and the wrap-around issue-id age compare.
// Ports:   none (package).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } alu_req_t;

  typedef struct packed {
    logic        flag;
    logic [31:0] result;
  } alu_ans_t;

  localparam int ALU_REQ_W = $bits(alu_req_t);
  localparam int ALU_ANS_W = $bits(alu_ans_t);

  // a is older than b when the top id bit of (a - b) mod 2^w is set. Taking the
  // bit straight from the 32-bit difference gives the same answer as reducing
  // modulo 2^w first.
  function automatic logic id_older(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned w);
    logic [31:0] diff;
    logic [4:0]  msb;
    diff = a - b;
    msb  = 5'(w - 1);
    return diff[msb];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - SIC request/answer and ALU handshake bundle
//
// Purpose: groups the per-SIC request/answer signals and the ALU-side handshake.
// Ports:   req_valid/req_id/req_payload (SIC -> arbiter), grant/ans_valid/ans_data
//          (arbiter -> SIC), alu_valid/alu_payload (arbiter -> ALU),
//          alu_ready/alu_done/alu_ans (ALU -> arbiter), busy/owner_id/timeout_err status.
//          Modport slave is the arbiter view, master is the environment view.
interface alu_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 4,
  parameter int ALU_REQ_W = alu_arb_pkg::ALU_REQ_W,
  parameter int ALU_ANS_W = alu_arb_pkg::ALU_ANS_W
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ID_WIDTH-1:0]  req_id;
  logic [NUM_REQ*ALU_REQ_W-1:0] req_payload;
  logic [NUM_REQ-1:0]           grant;
  logic                         alu_valid;
  logic [ALU_REQ_W-1:0]         alu_payload;
  logic                         alu_ready;
  logic                         alu_done;
  logic [ALU_ANS_W-1:0]         alu_ans;
  logic [NUM_REQ-1:0]           ans_valid;
  logic [ALU_ANS_W-1:0]         ans_data;
  logic                         busy;
  logic [ID_WIDTH-1:0]          owner_id;
  logic                         timeout_err;

  modport slave (
    input  req_valid, req_id, req_payload, alu_ready, alu_done, alu_ans,
    output grant, alu_valid, alu_payload, ans_valid, ans_data, busy, owner_id, timeout_err
  );

  modport master (
    output req_valid, req_id, req_payload, alu_ready, alu_done, alu_ans,
    input  grant, alu_valid, alu_payload, ans_valid, ans_data, busy, owner_id, timeout_err
  );
endinterface

// File: rtl/alu_age_picker.sv
// rtl/alu_age_picker.sv - combinational oldest-id picker with round-robin tie-break
//
// Purpose: selects the valid requester that no other valid requester is older than;
//          among equal ids the first one at or after rr_ptr (mod NUM_REQ) wins.
// Ports:   req_valid, req_id (packed per SIC), rr_ptr in; winner_oh (one-hot) and
//          winner_idx out. Both outputs are zero when nothing is valid.
module alu_age_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 4,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
  input  logic [IDX_W-1:0]            rr_ptr,
  output logic [NUM_REQ-1:0]          winner_oh,
  output logic [IDX_W-1:0]            winner_idx
);
  import alu_arb_pkg::*;

  logic [NUM_REQ-1:0] oldest;
  logic               found;

  always_comb begin
    oldest = req_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i != j && req_valid[j] &&
            id_older(32'(req_id[j*ID_WIDTH +: ID_WIDTH]),
                     32'(req_id[i*ID_WIDTH +: ID_WIDTH]), ID_WIDTH)) begin
          oldest[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && oldest[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        winner_oh[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        winner_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    // Ids outside the legal window can form an age cycle with no oldest member;
    // fall back to plain round-robin so a valid request is never stranded.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        winner_oh[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        winner_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - oldest-first arbiter sharing one ALU among NUM_REQ SICs
//
// Purpose: latches the oldest requester's op in IDLE, presents it in ISSUE until the
//          ALU accepts it (or the owner withdraws), holds ownership in WAIT until
//          alu_done or timeout, and routes the answer back to the owner only.
// Ports:   clk, rst (async, active-high); bus (alu_arbiter_if.slave) carrying the SIC
//          request/answer signals, the ALU handshake and busy/owner_id/timeout_err.
module alu_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 4,
  parameter int ALU_REQ_W = alu_arb_pkg::ALU_REQ_W,
  parameter int ALU_ANS_W = alu_arb_pkg::ALU_ANS_W,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  import alu_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_idx_q, owner_idx_d;
  logic [ID_WIDTH-1:0]  owner_id_q, owner_id_d;
  logic [ALU_REQ_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0]   winner_oh;
  logic [IDX_W-1:0]     winner_idx;
  logic [ID_WIDTH-1:0]  pick_id;
  logic [ALU_REQ_W-1:0] pick_payload;
  logic [NUM_REQ-1:0]   grant_c;
  logic [NUM_REQ-1:0]   ans_valid_c;
  logic                 ans_hit;
  logic                 timeout_c;

  alu_age_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req_valid  (bus.req_valid),
    .req_id     (bus.req_id),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (winner_oh),
    .winner_idx (winner_idx)
  );

  always_comb begin
    pick_id      = '0;
    pick_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_oh[i]) begin
        pick_id      = bus.req_id[i*ID_WIDTH +: ID_WIDTH];
        pick_payload = bus.req_payload[i*ALU_REQ_W +: ALU_REQ_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_idx_d = owner_idx_q;
    owner_id_d  = owner_id_q;
    payload_d   = payload_q;
    wait_cnt_d  = '0;
    grant_c     = '0;
    ans_hit     = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          owner_idx_d = winner_idx;
          owner_id_d  = pick_id;
          payload_d   = pick_payload;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn owner (flush) wins over alu_ready: the op is abandoned.
        if (!bus.req_valid[owner_idx_q]) begin
          state_d = IDLE;
        end else if (bus.alu_ready) begin
          grant_c[owner_idx_q] = 1'b1;
          rr_ptr_d = (owner_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx_q + 1'b1;
          if (bus.alu_done) begin
            ans_hit = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.alu_done) begin
          ans_hit = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without an answer.
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ans_valid_c = '0;
    if (ans_hit) ans_valid_c[owner_idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_idx_q <= '0;
      owner_id_q  <= '0;
      payload_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_idx_q <= owner_idx_d;
      owner_id_q  <= owner_id_d;
      payload_q   <= payload_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.grant       = grant_c;
  assign bus.alu_valid   = (state_q == ISSUE);
  assign bus.alu_payload = (state_q == ISSUE) ? payload_q : '0;
  assign bus.ans_valid   = ans_valid_c;
  assign bus.ans_data    = ans_hit ? bus.alu_ans : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.owner_id    = (state_q != IDLE) ? owner_id_q : '0;
  assign bus.timeout_err = timeout_c;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of the ALU arbiter
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int RW  = 72;
  localparam int AW  = 33;
  localparam int TO  = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rr_m  = 0;

  alu_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IDW), .ALU_REQ_W(RW), .ALU_ANS_W(AW)) bus ();

  alu_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .ALU_REQ_W(RW), .ALU_ANS_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [RW-1:0] rand72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand33();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[AW-1:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_id      = '0;
    bus.req_payload = '0;
    bus.alu_ready   = 1'b0;
    bus.alu_done    = 1'b0;
    bus.alu_ans     = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [IDW-1:0] id,
                         input logic [RW-1:0] p);
    bus.req_valid[i]              = v;
    bus.req_id[i*IDW +: IDW]      = id;
    bus.req_payload[i*RW +: RW]   = p;
  endtask

  task automatic pulse_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
    rr_m = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_req(0, 1'b1, 4'd3, rand72());
    bus.alu_ready = 1'b1;
    cyc(); cyc(); #1;
    total++;
    if ({bus.grant, bus.alu_valid, bus.ans_valid, bus.busy, bus.owner_id, bus.timeout_err} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got grant=%b alu_valid=%b ans_valid=%b busy=%b owner_id=%0d tmo=%b want all 0",
                      bus.grant, bus.alu_valid, bus.ans_valid, bus.busy, bus.owner_id, bus.timeout_err);
    end
    total++;
    if (bus.alu_payload !== '0 || bus.ans_data !== '0) begin
      bad++; $display("FAIL reset_data: got payload=%h ans_data=%h want 0", bus.alu_payload, bus.ans_data);
    end
    clear_inputs();
    rst = 1'b0;
    rr_m = 0;
    cyc(); #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    logic [RW-1:0] p;
    logic [AW-1:0] a;
    p = rand72();
    a = rand33();
    cyc();
    set_req(2, 1'b1, 4'd5, p);
    bus.alu_ready = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.alu_valid !== 1'b0) begin
      bad++; $display("FAIL single_c0: got busy=%b alu_valid=%b want 0 0", bus.busy, bus.alu_valid);
    end
    cyc(); #1;
    total++;
    if (bus.alu_valid !== 1'b1 || bus.grant !== 4'b0100 || bus.alu_payload !== p || bus.owner_id !== 4'd5) begin
      bad++; $display("FAIL single_c1: got alu_valid=%b grant=%b payload=%h owner=%0d want 1 0100 %h 5",
                      bus.alu_valid, bus.grant, bus.alu_payload, bus.owner_id, p);
    end
    cyc();
    set_req(2, 1'b0, 4'd0, '0);
    for (int c = 2; c <= 3; c++) begin
      #1;
      total++;
      if (bus.alu_valid !== 1'b0 || bus.busy !== 1'b1 || bus.ans_valid !== 4'b0000) begin
        bad++; $display("FAIL single_wait: cycle %0d got alu_valid=%b busy=%b ans_valid=%b want 0 1 0000",
                        c, bus.alu_valid, bus.busy, bus.ans_valid);
      end
      cyc();
    end
    bus.alu_done = 1'b1;
    bus.alu_ans  = a;
    #1;
    total++;
    if (bus.ans_valid !== 4'b0100 || bus.ans_data !== a) begin
      bad++; $display("FAIL single_ans: got ans_valid=%b ans_data=%h want 0100 %h", bus.ans_valid, bus.ans_data, a);
    end
    cyc();
    bus.alu_done = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.ans_valid !== 4'b0000 || bus.ans_data !== '0) begin
      bad++; $display("FAIL single_c5: got busy=%b ans_valid=%b ans_data=%h want 0 0000 0",
                      bus.busy, bus.ans_valid, bus.ans_data);
    end
    rr_m = 3;
  endtask

  task automatic test_age_wrap();
    logic [RW-1:0] p0, p1;
    p0 = rand72();
    p1 = rand72();
    cyc();
    set_req(0, 1'b1, 4'd14, p0);
    set_req(1, 1'b1, 4'd1, p1);
    bus.alu_ready = 1'b1;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0001 || bus.alu_payload !== p0) begin
      bad++; $display("FAIL age_first: got grant=%b payload=%h want 0001 %h", bus.grant, bus.alu_payload, p0);
    end
    cyc();
    set_req(0, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    bus.alu_ans  = 33'h1_2345_6789;
    #1;
    total++;
    if (bus.ans_valid !== 4'b0001 || bus.ans_data !== 33'h1_2345_6789) begin
      bad++; $display("FAIL age_ans0: got ans_valid=%b ans_data=%h want 0001 123456789", bus.ans_valid, bus.ans_data);
    end
    cyc();
    bus.alu_done = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      bad++; $display("FAIL age_gap: got busy=%b grant=%b want 0 0000", bus.busy, bus.grant);
    end
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0010 || bus.alu_payload !== p1 || bus.owner_id !== 4'd1) begin
      bad++; $display("FAIL age_second: got grant=%b payload=%h owner=%0d want 0010 %h 1",
                      bus.grant, bus.alu_payload, bus.owner_id, p1);
    end
    cyc();
    set_req(1, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
  endtask

  task automatic test_tie_rr();
    logic [RW-1:0] p0, p3, p0b;
    p0 = rand72(); p3 = rand72(); p0b = rand72();
    pulse_reset();
    set_req(0, 1'b1, 4'd7, p0);
    set_req(3, 1'b1, 4'd7, p3);
    bus.alu_ready = 1'b1;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0001 || bus.alu_payload !== p0) begin
      bad++; $display("FAIL tie_first: got grant=%b payload=%h want 0001 %h", bus.grant, bus.alu_payload, p0);
    end
    cyc();
    set_req(0, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
    set_req(0, 1'b1, 4'd7, p0b);
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b1000 || bus.alu_payload !== p3) begin
      bad++; $display("FAIL tie_rr: got grant=%b payload=%h want 1000 %h", bus.grant, bus.alu_payload, p3);
    end
    cyc();
    set_req(3, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0001 || bus.alu_payload !== p0b) begin
      bad++; $display("FAIL tie_third: got grant=%b payload=%h want 0001 %h", bus.grant, bus.alu_payload, p0b);
    end
    cyc();
    set_req(0, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
  endtask

  task automatic test_backpressure_withdraw();
    logic [RW-1:0] p, p2;
    logic [AW-1:0] a;
    p = rand72(); p2 = rand72(); a = rand33();
    cyc();
    set_req(1, 1'b1, 4'd3, p);
    bus.alu_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 2) bus.req_payload[RW +: RW] = ~p;
      #1;
      total++;
      if (bus.alu_valid !== 1'b1 || bus.grant !== 4'b0000 || bus.alu_payload !== p) begin
        bad++; $display("FAIL bp_hold: cycle %0d got alu_valid=%b grant=%b payload=%h want 1 0000 %h",
                        c, bus.alu_valid, bus.grant, bus.alu_payload, p);
      end
    end
    cyc();
    bus.req_valid[1] = 1'b0;
    bus.alu_ready    = 1'b1;
    #1;
    total++;
    if (bus.grant !== 4'b0000 || bus.alu_valid !== 1'b1) begin
      bad++; $display("FAIL withdraw_nogrant: got grant=%b alu_valid=%b want 0000 1", bus.grant, bus.alu_valid);
    end
    cyc();
    bus.alu_done = 1'b1;
    bus.alu_ans  = rand33();
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.ans_valid !== 4'b0000) begin
      bad++; $display("FAIL withdraw_idle: got busy=%b ans_valid=%b want 0 0000", bus.busy, bus.ans_valid);
    end
    bus.alu_done = 1'b0;
    cyc();
    set_req(1, 1'b1, 4'd3, p2);
    bus.alu_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc(); #1;
      total++;
      if (bus.grant !== 4'b0000 || bus.alu_payload !== p2) begin
        bad++; $display("FAIL bp_hold2: cycle %0d got grant=%b payload=%h want 0000 %h",
                        c, bus.grant, bus.alu_payload, p2);
      end
    end
    cyc();
    bus.alu_ready = 1'b1;
    bus.alu_done  = 1'b1;
    bus.alu_ans   = a;
    #1;
    total++;
    if (bus.grant !== 4'b0010 || bus.ans_valid !== 4'b0010 || bus.ans_data !== a) begin
      bad++; $display("FAIL bp_same_cycle: got grant=%b ans_valid=%b ans_data=%h want 0010 0010 %h",
                      bus.grant, bus.ans_valid, bus.ans_data, a);
    end
    cyc();
    set_req(1, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.ans_valid !== 4'b0000) begin
      bad++; $display("FAIL bp_after: got busy=%b ans_valid=%b want 0 0000", bus.busy, bus.ans_valid);
    end
  endtask

  task automatic test_timeout();
    cyc();
    set_req(0, 1'b1, 4'd2, rand72());
    bus.alu_ready = 1'b1;
    bus.alu_done  = 1'b0;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0001) begin
      bad++; $display("FAIL tmo_grant: got grant=%b want 0001", bus.grant);
    end
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == 1) set_req(0, 1'b0, 4'd0, '0);
      #1;
      total++;
      if (bus.timeout_err !== (k == TO) || bus.busy !== 1'b1 || bus.ans_valid !== 4'b0000) begin
        bad++; $display("FAIL tmo_wait: wait cycle %0d got timeout_err=%b busy=%b ans_valid=%b want %b 1 0000",
                        k, bus.timeout_err, bus.busy, bus.ans_valid, (k == TO));
      end
    end
    cyc();
    bus.alu_done = 1'b1;
    bus.alu_ans  = rand33();
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || bus.ans_valid !== 4'b0000 || bus.ans_data !== '0) begin
      bad++; $display("FAIL tmo_stray: got busy=%b timeout_err=%b ans_valid=%b ans_data=%h want 0 0 0000 0",
                      bus.busy, bus.timeout_err, bus.ans_valid, bus.ans_data);
    end
    bus.alu_done = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] p1;
    p1 = rand72();
    cyc();
    set_req(2, 1'b1, 4'd9, rand72());
    bus.alu_ready = 1'b1;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0100) begin
      bad++; $display("FAIL ares_grant: got grant=%b want 0100", bus.grant);
    end
    cyc();
    set_req(2, 1'b0, 4'd0, '0);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL ares_wait: got busy=%b want 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.grant, bus.alu_valid, bus.ans_valid, bus.busy, bus.owner_id, bus.timeout_err} !== '0 ||
        bus.alu_payload !== '0 || bus.ans_data !== '0) begin
      bad++; $display("FAIL ares_outputs: got busy=%b owner_id=%0d alu_valid=%b grant=%b want all 0",
                      bus.busy, bus.owner_id, bus.alu_valid, bus.grant);
    end
    cyc(); cyc();
    rst = 1'b0;
    rr_m = 0;
    set_req(1, 1'b1, 4'd4, p1);
    set_req(3, 1'b1, 4'd4, rand72());
    bus.alu_ready = 1'b1;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b0010 || bus.alu_payload !== p1) begin
      bad++; $display("FAIL ares_rr: got grant=%b payload=%h want 0010 %h", bus.grant, bus.alu_payload, p1);
    end
    cyc();
    set_req(1, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
    cyc(); #1;
    total++;
    if (bus.grant !== 4'b1000) begin
      bad++; $display("FAIL ares_next: got grant=%b want 1000", bus.grant);
    end
    cyc();
    set_req(3, 1'b0, 4'd0, '0);
    bus.alu_done = 1'b1;
    cyc();
    bus.alu_done = 1'b0;
  endtask

  // Model: ids of one batch lie within a window above a random base, so the oldest
  // request is the one with the smallest distance from base; ties go to the first
  // pending index at or after the model's round-robin pointer.
  task automatic test_random();
    logic [IDW-1:0] ids [N];
    logic [RW-1:0]  pays [N];
    logic [N-1:0]   pend;
    logic [N-1:0]   oh;
    logic [IDW-1:0] base, oi, ob;
    logic [AW-1:0]  ans;
    int best, d, dd, idx;
    pulse_reset();
    for (int r = 0; r < 30; r++) begin
      cyc();
      bus.alu_done = 1'b0;
      base = IDW'($urandom_range(0, 15));
      pend = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        ids[i]  = base + IDW'($urandom_range(0, 6));
        pays[i] = rand72();
        set_req(i, pend[i], ids[i], pays[i]);
      end
      while (pend != '0) begin
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
          bad++; $display("FAIL rnd_idle: round %0d got busy=%b want 0", r, bus.busy);
        end
        best = -1;
        for (int k = 0; k < N; k++) begin
          idx = (rr_m + k) % N;
          if (pend[idx]) begin
            oi = ids[idx] - base;
            if (best >= 0) ob = ids[best] - base;
            else ob = '0;
            if (best < 0 || oi < ob) best = idx;
          end
        end
        oh = N'(1) << best;
        cyc();
        d  = $urandom_range(0, 2);
        dd = $urandom_range(0, 3);
        for (int c = 0; c < d; c++) begin
          bus.alu_ready = 1'b0;
          #1;
          total++;
          if (bus.alu_valid !== 1'b1 || bus.grant !== '0 || bus.alu_payload !== pays[best] || bus.owner_id !== ids[best]) begin
            bad++; $display("FAIL rnd_stall: round %0d got alu_valid=%b grant=%b owner=%0d want 1 0000 %0d",
                            r, bus.alu_valid, bus.grant, bus.owner_id, ids[best]);
          end
          cyc();
        end
        bus.alu_ready = 1'b1;
        ans = rand33();
        if (dd == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_ans  = ans;
        end
        #1;
        total++;
        if (bus.grant !== oh) begin
          bad++; $display("FAIL rnd_grant: round %0d got grant=%b want %b", r, bus.grant, oh);
        end
        total++;
        if (bus.alu_payload !== pays[best] || bus.owner_id !== ids[best]) begin
          bad++; $display("FAIL rnd_payload: round %0d got payload=%h owner=%0d want %h %0d",
                          r, bus.alu_payload, bus.owner_id, pays[best], ids[best]);
        end
        if (dd == 0) begin
          total++;
          if (bus.ans_valid !== oh || bus.ans_data !== ans) begin
            bad++; $display("FAIL rnd_ans_now: round %0d got ans_valid=%b ans_data=%h want %b %h",
                            r, bus.ans_valid, bus.ans_data, oh, ans);
          end
        end
        rr_m = (best + 1) % N;
        pend[best] = 1'b0;
        cyc();
        set_req(best, 1'b0, ids[best], pays[best]);
        bus.alu_done  = 1'b0;
        bus.alu_ready = 1'($urandom_range(0, 1));
        for (int c = 1; c <= dd; c++) begin
          if (c == dd) begin
            bus.alu_done = 1'b1;
            bus.alu_ans  = ans;
          end
          #1;
          total++;
          if (bus.ans_valid !== ((c == dd) ? oh : '0) || bus.alu_valid !== 1'b0 ||
              bus.ans_data !== ((c == dd) ? ans : '0)) begin
            bad++; $display("FAIL rnd_wait: round %0d wait %0d got ans_valid=%b ans_data=%h alu_valid=%b want %b",
                            r, c, bus.ans_valid, bus.ans_data, bus.alu_valid, (c == dd) ? oh : '0);
          end
          cyc();
          bus.alu_done = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_age_wrap();
    test_tie_rr();
    test_backpressure_withdraw();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
